gs_shift_sequencer: RTL

- Sequences one full grayscale frame from the pattern buffer into the LED driver chain.
- For each channel, fetches a GS_BITS-wide word from a synchronous-read buffer and shifts it out MSB-first on serial/sclk.
- After the last channel, pulses lat and reports completion.
- Sits between the instruction Controller (which issues start on SEND_SIGNAL) and the driver pins; the Controller owns gsclk, this block does not.

---
 rtl/gs_shift_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gs_shift_sequencer.sv
// gs_shift_sequencer: streams one grayscale frame from the pattern buffer
// into the LED driver chain. Each channel word is fetched from a 1-cycle
// synchronous RAM, shifted out MSB-first on serial/sclk, highest channel
// first, and the frame is closed with a lat pulse followed by a done pulse.
module gs_shift_sequencer #(
   parameter int CHANNELS  = 16,
   parameter int GS_BITS   = 12,
   parameter int SCLK_DIV  = 2,
   parameter int LAT_TICKS = 3,
   parameter int AW        = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      rd_addr,
   input  logic [GS_BITS-1:0] rd_data,
   output logic               serial,
   output logic               sclk,
   output logic               lat
);

   // Counter widths leave one spare bit so the terminal value never wraps.
   localparam int PH_W  = $clog2(SCLK_DIV) + 1;
   localparam int BIT_W = $clog2(GS_BITS) + 1;
   localparam int LAT_W = $clog2(LAT_TICKS) + 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(GS_BITS - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT_TICKS - 1);
   localparam logic [AW-1:0]    ADDR_TOP = AW'(CHANNELS - 1);

   // Reject parameter sets the counters and address register cannot hold.
   if (CHANNELS < 1)  begin : g_bad_channels  $error("CHANNELS must be >= 1");  end
   if (GS_BITS < 1)   begin : g_bad_gs_bits   $error("GS_BITS must be >= 1");   end
   if (SCLK_DIV < 1)  begin : g_bad_sclk_div  $error("SCLK_DIV must be >= 1");  end
   if (LAT_TICKS < 1) begin : g_bad_lat_ticks $error("LAT_TICKS must be >= 1"); end
   if (AW < 1 || AW < $clog2(CHANNELS)) begin : g_bad_aw
      $error("AW too narrow for CHANNELS");
   end

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT,
      LATCH,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [AW-1:0]      rd_addr_q, rd_addr_d;
   logic               serial_q, serial_d;
   logic               sclk_q, sclk_d;
   logic               lat_q, lat_d;
   logic [GS_BITS-1:0] shreg_q, shreg_d;
   logic               fetch_cnt_q, fetch_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [PH_W-1:0]    phase_cnt_q, phase_cnt_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

   // Shift register advanced by one bit; its MSB is the next bit to present.
   logic [GS_BITS-1:0] shreg_next;
   assign shreg_next = shreg_q << 1;

   // State register and all output/counter registers, synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values computed by the combinational block.
      if (reset) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_addr_q   <= '0;
         serial_q    <= 1'b0;
         sclk_q      <= 1'b0;
         lat_q       <= 1'b0;
         shreg_q     <= '0;
         fetch_cnt_q <= 1'b0;
         bit_cnt_q   <= '0;
         phase_cnt_q <= '0;
         lat_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_addr_q   <= rd_addr_d;
         serial_q    <= serial_d;
         sclk_q      <= sclk_d;
         lat_q       <= lat_d;
         shreg_q     <= shreg_d;
         fetch_cnt_q <= fetch_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
      end
   end

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      // NOTE: every target gets its hold value first, so no path through the
      // case statement can leave a signal unassigned and infer a latch.
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = done_q;
      rd_addr_d   = rd_addr_q;
      serial_d    = serial_q;
      sclk_d      = sclk_q;
      lat_d       = lat_q;
      shreg_d     = shreg_q;
      fetch_cnt_d = fetch_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      phase_cnt_d = phase_cnt_q;
      lat_cnt_d   = lat_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = FETCH;
               busy_d      = 1'b1;
               rd_addr_d   = ADDR_TOP;
               fetch_cnt_d = 1'b0;
            end
         end

         // Cycle 0 presents the address to the RAM, cycle 1 sees its data.
         FETCH: begin
            if (fetch_cnt_q) begin
               shreg_d     = rd_data;
               serial_d    = rd_data[GS_BITS-1];
               sclk_d      = 1'b0;
               bit_cnt_d   = '0;
               phase_cnt_d = '0;
               fetch_cnt_d = 1'b0;
               state_d     = SHIFT;
            end else begin
               fetch_cnt_d = 1'b1;
            end
         end

         // Each bit: SCLK_DIV cycles low, then SCLK_DIV cycles high. serial
         // moves only together with the falling sclk edge.
         SHIFT: begin
            if (phase_cnt_q == PH_LAST) begin
               phase_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_cnt_q == BIT_LAST) begin
                  sclk_d = 1'b0;
                  if (rd_addr_q == '0) begin
                     lat_d     = 1'b1;
                     lat_cnt_d = '0;
                     state_d   = LATCH;
                  end else begin
                     rd_addr_d   = rd_addr_q - 1'b1;
                     fetch_cnt_d = 1'b0;
                     state_d     = FETCH;
                  end
               end else begin
                  sclk_d    = 1'b0;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shreg_d   = shreg_next;
                  serial_d  = shreg_next[GS_BITS-1];
               end
            end else begin
               phase_cnt_d = phase_cnt_q + 1'b1;
            end
         end

         LATCH: begin
            if (lat_cnt_q == LAT_LAST) begin
               lat_d   = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end

         DONE: begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_addr = rd_addr_q;
   assign serial  = serial_q;
   assign sclk    = sclk_q;
   assign lat     = lat_q;

endmodule
